// File: rtl/feed_rx_stage_pkg.sv
// Shared types for the exec-side feed receiver: machine word width, decoded
// instruction names, the buffered payload record and the launch FSM states.
package feed_rx_stage_pkg;

    localparam int XLEN  = 32;
    localparam int RRN_W = 6;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLL, I_SRL, I_SRA,
        I_SLT, I_SLTU, I_BEQ, I_BNE, I_BLT, I_BGE, I_LW, I_SW
    } instr_name_e;

    typedef struct packed {
        logic [XLEN-1:0]  data_1;
        logic [XLEN-1:0]  data_2;
        logic [XLEN-1:0]  address;
        logic [XLEN-1:0]  immediate;
        instr_name_e      instr_name;
        logic [RRN_W-1:0] rrn;
    } feed_payload_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_CDB
    } feed_rx_state_e;

endpackage

// File: rtl/feed_rx_stage_fifo.sv
// feed_fifo: small first-word-fall-through FIFO of feed payloads with a
// synchronous flush; the head entry is visible combinationally.
module feed_fifo
    import feed_rx_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  feed_payload_t          wr_data,
    output feed_payload_t          head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    feed_payload_t  mem [DEPTH];
    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [CW-1:0]  count_reg;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage is not reset: an entry is only ever read after it was written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clock) begin
            if (do_push && (tail_reg == PW'(gi))) begin
                mem[gi] <= wr_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (do_pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[head_reg];
    assign count = count_reg;

endmodule

// File: rtl/feed_rx_stage.sv
// feed_rx_stage: buffers station payloads, launches one instruction at a time
// into the unit and holds its result on the CDB until granted.
// Optional macro FEED_RX_BYPASS_EN: start straight from the feed bus when idle and empty.
module feed_rx_stage
    import feed_rx_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             feed_valid,
    output logic             feed_ready,
    input  logic [XLEN-1:0]  feed_data_1,
    input  logic [XLEN-1:0]  feed_data_2,
    input  logic [XLEN-1:0]  feed_address,
    input  logic [XLEN-1:0]  feed_immediate,
    input  instr_name_e      feed_instr_name,
    input  logic [RRN_W-1:0] feed_rrn,
    output logic             exec_start,
    output logic [XLEN-1:0]  exec_data_1,
    output logic [XLEN-1:0]  exec_data_2,
    output logic [XLEN-1:0]  exec_address,
    output logic [XLEN-1:0]  exec_immediate,
    output instr_name_e      exec_instr_name,
    input  logic             exec_done,
    input  logic [XLEN-1:0]  exec_result,
    output logic             cdb_req,
    output logic [XLEN-1:0]  cdb_result,
    output logic [RRN_W-1:0] cdb_rrn,
    input  logic             cdb_grant
);

    localparam int CW = $clog2(DEPTH) + 1;

    feed_rx_state_e   state_reg;
    feed_rx_state_e   state_next;
    logic [XLEN-1:0]  cdb_result_reg;
    logic [RRN_W-1:0] cdb_rrn_reg;
    feed_payload_t    feed_payload;
    feed_payload_t    head;
    feed_payload_t    exec_payload;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             cdb_load;

    assign feed_payload = '{
        data_1:     feed_data_1,
        data_2:     feed_data_2,
        address:    feed_address,
        immediate:  feed_immediate,
        instr_name: feed_instr_name,
        rrn:        feed_rrn
    };

    assign feed_ready = !reset && (fifo_count < CW'(DEPTH));
    assign push       = feed_valid && feed_ready && !flush;

    feed_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_data (feed_payload),
        .head    (head),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        exec_start = 1'b0;
        pop        = 1'b0;
        cdb_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    exec_start = 1'b1;
                    state_next = RUN;
`ifdef FEED_RX_BYPASS_EN
                end else if (push) begin
                    exec_start = 1'b1;
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                if (exec_done) begin
                    cdb_load   = 1'b1;
                    state_next = WAIT_CDB;
                end
            end
            WAIT_CDB: begin
                if (cdb_grant) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Kill wins over every other event in the same cycle.
        if (reset || flush) begin
            exec_start = 1'b0;
            pop        = 1'b0;
            cdb_load   = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        state_reg <= state_next;
        if (reset || flush) begin
            cdb_result_reg <= '0;
            cdb_rrn_reg    <= '0;
        end else if (cdb_load) begin
            cdb_result_reg <= exec_result;
            cdb_rrn_reg    <= head.rrn;
        end
    end

`ifdef FEED_RX_BYPASS_EN
    logic bypass_sel;
    // The bypassed payload is also written, so it becomes the head next cycle.
    assign bypass_sel   = (state_reg == IDLE) && fifo_empty && push;
    assign exec_payload = bypass_sel ? feed_payload : head;
`else
    assign exec_payload = head;
`endif

    assign exec_data_1     = exec_payload.data_1;
    assign exec_data_2     = exec_payload.data_2;
    assign exec_address    = exec_payload.address;
    assign exec_immediate  = exec_payload.immediate;
    assign exec_instr_name = exec_payload.instr_name;

    assign cdb_req    = (state_reg == WAIT_CDB);
    assign cdb_result = cdb_result_reg;
    assign cdb_rrn    = cdb_rrn_reg;

endmodule

// File: tb/tb_feed_rx_stage.sv
// Self-checking bench for feed_rx_stage: directed scenarios followed by random
// traffic, all checked against a transaction-level queue model.
module tb_feed_rx_stage;
    import feed_rx_stage_pkg::*;

    localparam int DEPTH = 2;
`ifdef FEED_RX_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             flush;
    logic             feed_valid;
    feed_payload_t    feed_p;
    logic             exec_done;
    logic [XLEN-1:0]  exec_result;
    logic             cdb_grant;
    logic             feed_ready;
    logic             exec_start;
    logic [XLEN-1:0]  exec_data_1;
    logic [XLEN-1:0]  exec_data_2;
    logic [XLEN-1:0]  exec_address;
    logic [XLEN-1:0]  exec_immediate;
    instr_name_e      exec_instr_name;
    logic             cdb_req;
    logic [XLEN-1:0]  cdb_result;
    logic [RRN_W-1:0] cdb_rrn;

    feed_rx_stage #(.DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .feed_valid      (feed_valid),
        .feed_ready      (feed_ready),
        .feed_data_1     (feed_p.data_1),
        .feed_data_2     (feed_p.data_2),
        .feed_address    (feed_p.address),
        .feed_immediate  (feed_p.immediate),
        .feed_instr_name (feed_p.instr_name),
        .feed_rrn        (feed_p.rrn),
        .exec_start      (exec_start),
        .exec_data_1     (exec_data_1),
        .exec_data_2     (exec_data_2),
        .exec_address    (exec_address),
        .exec_immediate  (exec_immediate),
        .exec_instr_name (exec_instr_name),
        .exec_done       (exec_done),
        .exec_result     (exec_result),
        .cdb_req         (cdb_req),
        .cdb_result      (cdb_result),
        .cdb_rrn         (cdb_rrn),
        .cdb_grant       (cdb_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: accepted-but-unretired payloads plus the life of the
    // one instruction in flight (0 none, 1 executing, 2 result on CDB).
    int               checks = 0;
    int               errors = 0;
    feed_payload_t    mq[$];
    feed_payload_t    stq[$];
    logic [RRN_W-1:0] granted[$];
    int               phase = 0;
    logic [XLEN-1:0]  exp_res = '0;
    logic [RRN_W-1:0] exp_rrn = '0;
    int               unit_lat = 0;
    logic [XLEN-1:0]  unit_res = '0;
    bit               lat_rand = 1'b0;

    bit               s_start, s_ready, s_req, s_push;
    logic [XLEN-1:0]  s_res, s_d1;
    logic [RRN_W-1:0] s_rrn;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic feed_payload_t rand_payload();
        feed_payload_t p;
        p.data_1     = $urandom;
        p.data_2     = $urandom;
        p.address    = $urandom;
        p.immediate  = $urandom;
        p.instr_name = instr_name_e'($urandom_range(0, 15));
        p.rrn        = RRN_W'($urandom_range(0, 63));
        return p;
    endfunction

    task automatic idle_inputs();
        reset      = 1'b0;
        flush      = 1'b0;
        feed_valid = 1'b0;
        exec_done  = 1'b0;
        cdb_grant  = 1'b0;
    endtask

    // One clock: inputs are already set; check at the falling edge, then
    // advance the model across the rising edge.
    task automatic cycle();
        bit            exp_ready, push, start, pop;
        feed_payload_t exp_op;
        @(negedge clock);
        exp_ready = !reset && (mq.size() < DEPTH);
        push      = feed_valid && exp_ready && !flush;
        start     = !reset && !flush && (phase == 0) && ((mq.size() > 0) || (BYPASS && push));
        chk("feed_ready", feed_ready, exp_ready);
        chk("exec_start", exec_start, start);
        if (start || (phase != 0 && mq.size() > 0)) begin
            exp_op = (mq.size() > 0) ? mq[0] : feed_p;
            chk("exec_data_1", exec_data_1, exp_op.data_1);
            chk("exec_data_2", exec_data_2, exp_op.data_2);
            chk("exec_address", exec_address, exp_op.address);
            chk("exec_immediate", exec_immediate, exp_op.immediate);
            chk("exec_instr_name", exec_instr_name, exp_op.instr_name);
        end
        chk("cdb_req", cdb_req, phase == 2);
        chk("cdb_result", cdb_result, exp_res);
        chk("cdb_rrn", cdb_rrn, exp_rrn);
        s_start = exec_start;  s_ready = feed_ready;  s_req = cdb_req;
        s_res   = cdb_result;  s_rrn   = cdb_rrn;     s_d1  = exec_data_1;
        s_push  = push;
        @(posedge clock);
        pop = 1'b0;
        if (reset || flush) begin
            mq.delete();
            phase   = 0;
            exp_res = '0;
            exp_rrn = '0;
            s_push  = 1'b0;
        end else begin
            if (phase == 0 && start) begin
                phase    = 1;
                unit_lat = lat_rand ? $urandom_range(0, 3) : 0;
                unit_res = $urandom;
            end else if (phase == 1 && exec_done) begin
                phase   = 2;
                exp_res = exec_result;
                exp_rrn = (mq.size() > 0) ? mq[0].rrn : feed_p.rrn;
            end else if (phase == 2 && cdb_grant) begin
                phase = 0;
                granted.push_back(exp_rrn);
                pop = 1'b1;
            end
            if (pop) mq.pop_front();
            if (push) mq.push_back(feed_p);
        end
        #1;
    endtask

    // Station and execution unit behaviour driven from the model state.
    task automatic auto_cycles(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd && stq.size() == 0 && $urandom_range(0, 2) == 0) stq.push_back(rand_payload());
            if (stq.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                feed_valid = 1'b1;
                feed_p     = stq[0];
            end else begin
                feed_valid = 1'b0;
                feed_p     = rand_payload();
            end
            exec_done   = 1'b0;
            exec_result = $urandom;
            if (phase == 1) begin
                if (unit_lat == 0) begin
                    exec_done   = 1'b1;
                    exec_result = unit_res;
                end else begin
                    unit_lat--;
                end
            end else if (rnd && $urandom_range(0, 7) == 0) begin
                exec_done = 1'b1;
            end
            cdb_grant = (phase == 2) && (!rnd || $urandom_range(0, 1) == 1);
            flush     = rnd && ($urandom_range(0, 63) == 0);
            reset     = rnd && ($urandom_range(0, 127) == 0);
            cycle();
            if (s_push) void'(stq.pop_front());
        end
    endtask

    task automatic reach_phase(input int target);
        for (int k = 0; k < 30 && phase != target; k++) auto_cycles(1, 1'b0);
    endtask

    logic [XLEN-1:0] held_res;
    logic [XLEN-1:0] c0_d1;
    bit              c0_start;
    bit              full_seen;

    initial begin
        idle_inputs();
        feed_p      = '0;
        exec_result = '0;
        reset       = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        cycle();
        chk("rst_ready", s_ready, 1'b1);
        chk("rst_req", s_req, 1'b0);

        // Single instruction with exact cycle timing
        idle_inputs();
        feed_valid = 1'b1;
        feed_p = '{data_1: 32'd3, data_2: 32'd4, address: 32'h100, immediate: 32'd0,
                   instr_name: I_ADD, rrn: 6'd5};
        cycle();
        c0_start = s_start;
        c0_d1    = s_d1;
        chk("t1_start_c0", c0_start, BYPASS);
        idle_inputs();
        feed_p = rand_payload();
        cycle();
        chk("t1_start_c1", s_start, !BYPASS);
        chk("t1_data_1", BYPASS ? c0_d1 : s_d1, 32'd3);
        cycle();
        exec_done   = 1'b1;
        exec_result = 32'd7;
        cycle();
        idle_inputs();
        cdb_grant = 1'b1;
        cycle();
        chk("t1_req_c4", s_req, 1'b1);
        chk("t1_rrn_c4", s_rrn, 6'd5);
        chk("t1_res_c4", s_res, 32'd7);
        idle_inputs();
        cycle();
        chk("t1_req_c5", s_req, 1'b0);
        chk("t1_ready_c5", s_ready, 1'b1);

        // Back-to-back pushes beyond DEPTH, results in order
        granted.delete();
        full_seen = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            feed_payload_t p;
            p     = rand_payload();
            p.rrn = RRN_W'(r);
            stq.push_back(p);
        end
        for (int k = 0; k < 20; k++) begin
            auto_cycles(1, 1'b0);
            if (!s_ready) full_seen = 1'b1;
        end
        chk("t2_full_seen", full_seen, 1'b1);
        chk("t2_count", granted.size(), 3);
        for (int r = 0; r < 3 && r < granted.size(); r++) chk("t2_order", granted[r], r + 1);

        // Flush in WAIT_CDB with concurrent push and grant
        stq.push_back(rand_payload());
        reach_phase(2);
        idle_inputs();
        flush      = 1'b1;
        feed_valid = 1'b1;
        cdb_grant  = 1'b1;
        feed_p     = rand_payload();
        cycle();
        chk("t3_req_pre", s_req, 1'b1);
        idle_inputs();
        cycle();
        chk("t3_req", s_req, 1'b0);
        chk("t3_start", s_start, 1'b0);
        chk("t3_ready", s_ready, 1'b1);

        // exec_done outside RUN is ignored
        idle_inputs();
        exec_done   = 1'b1;
        exec_result = 32'hDEAD_BEEF;
        cycle();
        idle_inputs();
        cycle();
        chk("t4_idle_req", s_req, 1'b0);
        chk("t4_idle_res", s_res, 32'd0);
        stq.push_back(rand_payload());
        reach_phase(2);
        held_res    = exp_res;
        idle_inputs();
        exec_done   = 1'b1;
        exec_result = ~held_res;
        cycle();
        idle_inputs();
        cycle();
        chk("t4_wait_req", s_req, 1'b1);
        chk("t4_wait_res", s_res, held_res);
        auto_cycles(3, 1'b0);

        // Reset held for three cycles in the middle of RUN
        stq.push_back(rand_payload());
        reach_phase(1);
        idle_inputs();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_ready_rst", s_ready, 1'b0);
        end
        idle_inputs();
        cycle();
        chk("t5_ready_after", s_ready, 1'b1);
        chk("t5_req_after", s_req, 1'b0);
        chk("t5_start_after", s_start, 1'b0);
        chk("t5_res_after", s_res, 32'd0);

        // Random traffic with flushes, resets and stray completions
        lat_rand = 1'b1;
        auto_cycles(3000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
